wfifo_wr_arbiter: RTL and testbench
===================================

// Module: wfifo_wr_arbiter
// PURPOSE
//   Shares the write port of the async FIFO (write-side pointer/full logic) among NREQ
//   requesters in the wclk domain. Round-robin arbitration with packet-aware grant hold:
//   a granted requester keeps the port until it signals last or hits MAX_BURST words.
//   Drives winc/wdata into the FIFO and honours wfull as back-pressure.
// PARAMETERS
//   NREQ       4   number of requesters; power of two, >= 2
//   DSIZE      8   data word width
//   MAX_BURST  8   max words per grant before forced release; 1..256
//   IDW        2   grant index width, = log2(NREQ); set consistently with NREQ
// PORTS
//   wclk       in   1           write clock
//   wrst_n     in   1           reset, asynchronous, active-low
//   req_valid  in   NREQ        per-requester word valid
//   req_last   in   NREQ        per-requester last word of packet (qualified by valid)
//   req_data   in   NREQ*DSIZE  per-requester data; requester i at [i*DSIZE +: DSIZE]
//   req_ready  out  NREQ        per-requester accept; transfer = valid & ready
//   wfull      in   1           FIFO full flag (registered, wclk domain)
//   winc       out  1           FIFO write strobe
//   wdata      out  DSIZE       FIFO write data
//   grant_id   out  IDW         index of current owner (valid when busy=1)
//   busy       out  1           1 while in GRANT state
// BEHAVIOUR
//   - Reset (async, wrst_n=0): state=IDLE, last_grant=NREQ-1 (first grant goes to 0),
//     burst_cnt=0, grant_id=0, busy=0; req_ready=0, winc=0, wdata=0 at once, combinationally.
//   - FSM, 2 states:
//     IDLE : req_ready=0, winc=0, wdata=0. If any req_valid, pick first asserted index
//            scanning last_grant+1, +2, ... mod NREQ; register grant_id, burst_cnt=0,
//            go GRANT. No request -> stay IDLE. Arbitration latency = 1 cycle.
//     GRANT: g=grant_id. req_ready[g]=~wfull, all other ready=0.
//            winc=req_valid[g] & ~wfull; wdata=req_data[g] (combinational pass-through).
//            On transfer: burst_cnt+1. Release (-> IDLE, last_grant<=g, burst_cnt<=0)
//            when transfer with req_last[g]=1 OR transfer with burst_cnt==MAX_BURST-1.
//            No transfer (valid low or wfull=1): hold grant, no count change.
//   - Grant held while owner's valid drops mid-packet; no timeout, other requesters wait.
//   - wfull=1: winc never asserted; data held by requester (valid/ready protocol).
//   - Release cycle always followed by one IDLE cycle (one-cycle bubble between grants),
//     even if other requesters are pending.
//   - burst_cnt width 8 bits; compare exact, never wraps past MAX_BURST-1.
//   - Requester data must stay stable while valid & ~ready; arbiter does not buffer.
//   - Reset mid-packet: grant dropped immediately; partial packet already in FIFO
//     is not retracted (FIFO is reset by the same wrst_n).
// TESTING
//   1 Reset: wrst_n=0 with all req_valid=1 -> winc=0, req_ready=0, busy=0; after release,
//     first grant_id=0 after exactly one wclk edge.
//   2 Round-robin: req_valid=4'b1111, every word last=1, wfull=0 -> grant sequence
//     0,1,2,3,0 each for one word, IDLE bubble between each; winc pattern 1,0,1,0...
//   3 Packet hold: req0 sends 3-word packet (last on 3rd), req1 valid throughout ->
//     req1 ready=0 until req0's 3rd transfer; grant_id=1 two cycles after it.
//   4 Burst cap: MAX_BURST=8, req2 streams 20 words, last never set, req3 valid ->
//     req2 released after 8 transfers, req3 granted next, req2 resumes after req3.
//   5 Back-pressure: wfull=1 for 5 cycles mid-packet -> winc=0, req_ready[g]=0,
//     burst_cnt frozen, grant_id unchanged; transfers resume the cycle wfull drops.
//   6 Reset mid-packet: assert wrst_n=0 during GRANT of req1 word 2 -> winc and
//     req_ready drop without clock; post-reset first grant goes to requester 0.

Source files
------------

// File: rtl/wfifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wfifo_wr_arbiter
// Purpose  : Round-robin arbiter for the async FIFO write port, holding the
//            grant until the owner signals last or reaches MAX_BURST words.
// Revision : 1.0
// ============================================================================
module wfifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 8,
  parameter int IDW       = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] C_BURST_LAST = 8'(MAX_BURST - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] w_last_grant_nxt;
  logic [IDW-1:0] r_grant_id;
  logic [IDW-1:0] w_grant_id_nxt;
  logic [7:0]     r_burst_cnt;
  logic [7:0]     w_burst_cnt_nxt;
  logic [IDW-1:0] w_pick;
  logic [IDW-1:0] w_idx;
  logic           w_found;
  logic           w_xfer;
  logic           w_release;

  // Scan from the requester after the last owner; index arithmetic wraps mod NREQ.
  always_comb begin : arb_scan
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = r_last_grant + IDW'(k);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin : fsm_next
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_grant_id_nxt   = r_grant_id;
    w_burst_cnt_nxt  = r_burst_cnt;
    req_ready        = '0;
    winc             = 1'b0;
    wdata            = '0;
    w_xfer           = 1'b0;
    w_release        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt     = ST_GRANT;
          w_grant_id_nxt  = w_pick;
          w_burst_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        req_ready[r_grant_id] = ~wfull;
        wdata                 = req_data[int'(r_grant_id)*DSIZE +: DSIZE];
        w_xfer                = req_valid[r_grant_id] & ~wfull;
        winc                  = w_xfer;
        w_release             = w_xfer & (req_last[r_grant_id] | (r_burst_cnt == C_BURST_LAST));
        if (w_release) begin
          w_state_nxt      = ST_IDLE;
          w_last_grant_nxt = r_grant_id;
          w_burst_cnt_nxt  = '0;
        end else if (w_xfer) begin
          w_burst_cnt_nxt = r_burst_cnt + 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin : fsm_reg
    if (!wrst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IDW'(NREQ - 1);
      r_grant_id   <= '0;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_wfifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wfifo_wr_arbiter
// Purpose  : Directed bench with valid/ready sources and a write scoreboard.
// Revision : 1.0
// ============================================================================
module tb_wfifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;

  logic                  wclk;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [1:0]            grant_id;
  logic                  busy;

  wfifo_wr_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(8), .IDW(2)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .grant_id(grant_id), .busy(busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int checks   = 0;
  int failures = 0;

  // Requester sources: per-requester word FIFOs of {last, data}
  logic [8:0]      src_mem [NREQ][64];
  int              hd [NREQ];
  int              tl [NREQ];
  logic [NREQ-1:0] cap;

  logic [9:0] exp_q [$];
  logic [9:0] exp_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_src(input int i, input logic [7:0] d, input logic l);
    src_mem[i][tl[i]] = {l, d};
    tl[i]++;
  endtask

  task automatic exp_push(input int g, input logic [7:0] d);
    logic [1:0] gi;
    gi = g[1:0];
    exp_q.push_back({gi, d});
  endtask

  task automatic update_drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = (hd[i] != tl[i]);
      req_last[i]            = src_mem[i][hd[i]][8];
      req_data[i*DSIZE +: DSIZE] = src_mem[i][hd[i]][7:0];
    end
  endtask

  task automatic to_neg();
    @(negedge wclk);
    cap = req_valid & req_ready;
  endtask

  task automatic finish_cycle();
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) if (cap[i]) hd[i]++;
    update_drive();
  endtask

  // Scoreboard monitor: every FIFO write must match the next expected word
  always @(negedge wclk) begin
    if (winc === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: write grant=%0d data=%0h, none required", grant_id, wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({grant_id, wdata} !== exp_w) begin
          failures++;
          $display("FAIL sb_write: got grant=%0d data=%0h required grant=%0d data=%0h",
                   grant_id, wdata, exp_w[9:8], exp_w[7:0]);
        end
      end
    end
  end

  initial begin
    wrst_n    = 1'b0;
    wfull     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    cap       = '0;
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      for (int j = 0; j < 64; j++) src_mem[i][j] = '0;
    end

    // Reset with every requester valid, then round-robin of single-word packets
    push_src(0, 8'hA0, 1'b1); push_src(1, 8'hA1, 1'b1);
    push_src(2, 8'hA2, 1'b1); push_src(3, 8'hA3, 1'b1);
    push_src(0, 8'hA4, 1'b1);
    exp_push(0, 8'hA0); exp_push(1, 8'hA1); exp_push(2, 8'hA2);
    exp_push(3, 8'hA3); exp_push(0, 8'hA4);
    update_drive();
    repeat (2) @(posedge wclk);
    to_neg();
    chk("rst_winc", 32'(winc), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      to_neg();
      chk("rr_winc", 32'(winc), 32'(n % 2));
      if (n == 0) chk("rr_busy0", 32'(busy), 32'd0);
      if (n == 1) begin
        chk("rr_busy1", 32'(busy), 32'd1);
        chk("rr_first_gid", 32'(grant_id), 32'd0);
      end
      finish_cycle();
    end

    // Packet hold: req0 three words, req1 waiting
    wrst_n = 1'b0;
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    push_src(0, 8'hB0, 1'b0); push_src(0, 8'hB1, 1'b0); push_src(0, 8'hB2, 1'b1);
    push_src(1, 8'hC0, 1'b0); push_src(1, 8'hC1, 1'b1);
    exp_push(0, 8'hB0); exp_push(0, 8'hB1); exp_push(0, 8'hB2);
    exp_push(1, 8'hC0); exp_push(1, 8'hC1);
    update_drive();
    for (int n = 0; n < 8; n++) begin
      to_neg();
      if (n <= 4) chk("hold_rdy1", 32'(req_ready[1]), 32'd0);
      if (n == 1) chk("hold_rdy0", 32'(req_ready[0]), 32'd1);
      if (n == 4) chk("hold_bubble", 32'(busy), 32'd0);
      if (n == 5) chk("hold_gid1", 32'(grant_id), 32'd1);
      finish_cycle();
    end

    // Burst cap: req2 streams 20 words without last, req3 has a 2-word packet
    for (int k = 0; k < 20; k++) push_src(2, 8'(8'h40 + k), 1'b0);
    push_src(3, 8'hF0, 1'b0); push_src(3, 8'hF1, 1'b1);
    for (int k = 0; k < 8; k++) exp_push(2, 8'(8'h40 + k));
    exp_push(3, 8'hF0); exp_push(3, 8'hF1);
    for (int k = 8; k < 20; k++) exp_push(2, 8'(8'h40 + k));
    update_drive();
    for (int n = 0; n < 30; n++) begin
      to_neg();
      if (n == 8) chk("cap_last_gid", 32'(grant_id), 32'd2);
      if (n == 9) chk("cap_bubble", 32'(busy), 32'd0);
      if (n == 10) chk("cap_gid3", 32'(grant_id), 32'd3);
      if (n == 13) chk("cap_resume_gid2", 32'(grant_id), 32'd2);
      if (n == 29) begin
        chk("idle_owner_busy", 32'(busy), 32'd1);
        chk("idle_owner_gid", 32'(grant_id), 32'd2);
        chk("idle_owner_winc", 32'(winc), 32'd0);
      end
      finish_cycle();
    end

    // Back-pressure mid-burst: req2 already has 4 words of its burst counted
    for (int k = 0; k < 4; k++) push_src(2, 8'(8'h60 + k), 1'b0);
    for (int k = 0; k < 4; k++) exp_push(2, 8'(8'h60 + k));
    wfull = 1'b1;
    update_drive();
    for (int m = 0; m < 10; m++) begin
      to_neg();
      if (m < 5) begin
        chk("bp_winc", 32'(winc), 32'd0);
        chk("bp_ready", 32'(req_ready), 32'd0);
        chk("bp_gid", 32'(grant_id), 32'd2);
      end
      if (m == 5) begin
        chk("bp_resume_winc", 32'(winc), 32'd1);
        chk("bp_resume_ready", 32'(req_ready), 32'h4);
      end
      if (m == 8) chk("bp_cnt_busy", 32'(busy), 32'd1);
      if (m == 9) chk("bp_cnt_release", 32'(busy), 32'd0);
      finish_cycle();
      if (m == 4) wfull = 1'b0;
    end

    // Reset during req1's second word
    push_src(1, 8'h80, 1'b0); push_src(1, 8'h81, 1'b0); push_src(1, 8'h82, 1'b1);
    exp_push(1, 8'h80); exp_push(1, 8'h81);
    update_drive();
    to_neg();
    finish_cycle();
    to_neg();
    chk("mid_gid1", 32'(grant_id), 32'd1);
    finish_cycle();
    to_neg();
    chk("mid_word2_winc", 32'(winc), 32'd1);
    #1 wrst_n = 1'b0;
    #1;
    chk("mid_rst_winc", 32'(winc), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NREQ; i++) hd[i] = tl[i];
    update_drive();
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    push_src(1, 8'h91, 1'b1);
    push_src(0, 8'h90, 1'b1);
    exp_push(0, 8'h90); exp_push(1, 8'h91);
    update_drive();
    for (int n = 0; n < 6; n++) begin
      to_neg();
      if (n == 1) chk("post_rst_gid0", 32'(grant_id), 32'd0);
      if (n == 3) chk("post_rst_gid1", 32'(grant_id), 32'd1);
      finish_cycle();
    end

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
